frame_sync_receiver: RTL and testbench
======================================

# frame_sync_receiver

Parametrised serial frame receiver for the 802.11a bit-level receive path. It hunts for an alternating-bit preamble and aligns on a configurable start-of-frame delimiter (SFD). It then captures a length field and streams the payload out descrambled with the 802.11a x^7+x^4+1 sequence, flagging sync and length faults on `Error`. It replaces the fixed-pattern receiver and sits between the bit slicer and the deinterleaver/decoder.

## Interface
- `PRE_MIN`, 32: consecutive alternating bits required to declare preamble lock (≥4).
- `SFD_W`, 16: SFD width in bits.
- `SFD`, 16'hF3A0: SFD pattern, MSB received first. Must not be a substring of the alternating pattern.
- `SFD_TIMEOUT`, 64: cycles allowed after lock to find the SFD.
- `LEN_W`, 12: length-field width, MSB first.
- `MAX_LEN`, 4095: largest legal payload length in bits.
- `DESCRAMBLE`, 1: 1 = XOR payload with scrambler output; 0 = pass the payload through.
- `SEED`, 7'h7F: scrambler state loaded at payload start.
- `Clock` input 1: single clock; all logic on the rising edge.
- `Reset` input 1: asynchronous, active-high.
- `Input` input 1: serial bit, one bit per cycle.
- `Output` output 1: payload bit, registered.
- `OutValid` output 1: `Output` holds a payload bit.
- `FrameStart` output 1: one-cycle pulse on SFD match.
- `FrameDone` output 1: one-cycle pulse together with the last payload bit.
- `Error` output 1: one-cycle pulse on SFD timeout or illegal length.

## Operation
- States: HUNT, SYNC, LENGTH, PAYLOAD.
- **HUNT**
  - Track the previous bit. The alternation counter increments when `Input` differs from the previous bit and reloads to 1 otherwise.
  - Counter reaching `PRE_MIN` → SYNC. The timeout counter clears.
- **SYNC**
  - Shift `Input` into an `SFD_W`-bit register every cycle. That register also runs during HUNT, so an SFD straddling the preamble end is still caught.
  - Register equal to `SFD` → `FrameStart` pulse, go to LENGTH.
  - Timeout counter reaching `SFD_TIMEOUT` with no match → `Error` pulse, go to HUNT.
- **LENGTH**
  - Shift in `LEN_W` bits.
  - After the last bit: length == 0 or > `MAX_LEN` → `Error` pulse, go to HUNT.
  - Otherwise load the payload counter with the length and the scrambler with `SEED`, then go to PAYLOAD.
- **PAYLOAD**, each cycle:
  - fb = s[6]^s[3].
  - `Output` = `Input` ^ (fb & `DESCRAMBLE`), `OutValid` = 1.
  - s ← {s[5:0], fb}.
  - Decrement the payload counter.
  - On the bit that takes the counter from 1 to 0: `FrameDone` = 1, go to HUNT.
- Counter width rules:
  - Alternation counter: $clog2(`PRE_MIN`+1).
  - Timeout counter: $clog2(`SFD_TIMEOUT`+1).
  - Payload counter: `LEN_W`.
- Counters saturate; none of them wraps.
- Input is ignored outside PAYLOAD except for hunting and matching. Back-to-back frames need a fresh preamble.

## Timing
- Reset values: `Output`, `OutValid`, `FrameStart`, `FrameDone`, `Error` = 0. State = HUNT, all counters and shift registers 0, scrambler = `SEED`.
- Reset mid-frame: immediate return to HUNT. No `FrameDone` and no `Error` are emitted.
- Latency: one cycle. The bit sampled at edge n appears on `Output` after edge n, valid until edge n+1.
- `FrameStart` is asserted in the cycle after the last SFD bit is sampled. The first length bit is sampled at that same edge.
- `OutValid` stays high for exactly length consecutive cycles.
- `Error` and `FrameDone` are never high together.
- A preamble arriving during PAYLOAD is treated as data.

## Structure
- Package `rx_pkg`:
  - State enum.
  - Scrambler polynomial taps (6, 3).
  - Default `SFD` and `SEED` constants.
- Sub-module `descrambler_7`: 7-bit LFSR with load (seed), advance, and bypass inputs. Reused by the transmit scrambler.

## Test plan
- Reset: `Reset`=1 for 3 cycles, `Input` toggling → all outputs 0, state HUNT.
- Basic frame, `DESCRAMBLE`=0:
  - Stimulus: 40 bits 1010…, then SFD F3A0, then length 12'd4, then payload 1,0,0,1.
  - Response: `FrameStart` once; `Output` 1,0,0,1 with `OutValid` for 4 cycles; `FrameDone` on the 4th bit.
- Descrambler, `SEED`=7'h7F: 8 payload zeros → `Output` 0,0,0,0,1,1,1,0.
- SFD timeout: 40-bit preamble, then 64 cycles of constant 0 → `Error` pulse at cycle 64 after lock, no `OutValid`.
- Illegal length:
  - 12'd0 → `Error` one cycle after the last length bit, back to HUNT.
  - A following good frame decodes correctly.
- Reset mid-payload: assert `Reset` on payload bit 2 of a length-8 frame → `OutValid` drops immediately, no `FrameDone`, next frame decodes normally.

Source files
------------

// File: rtl/frame_sync_receiver_pkg.sv
// Shared definitions for the bit-level frame receiver: FSM states,
// scrambler taps and the default SFD / seed constants.
package rx_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    SYNC    = 2'd1,
    LENGTH  = 2'd2,
    PAYLOAD = 2'd3
  } rx_state_t;

  localparam int TAP_HI = 6;
  localparam int TAP_LO = 3;

  localparam logic [15:0] DEF_SFD  = 16'hF3A0;
  localparam logic [6:0]  DEF_SEED = 7'h7F;

  function automatic logic lfsr_fb(input logic [6:0] s);
    return s[TAP_HI] ^ s[TAP_LO];
  endfunction

endpackage

// File: rtl/descrambler_7.sv
// 7-bit x^7+x^4+1 LFSR (de)scrambler with seed load, advance and bypass.
// The data path is combinational; the caller registers the result.
module descrambler_7 import rx_pkg::*; #(
  parameter logic [6:0] SEED = DEF_SEED
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_adv,
  input  logic i_bypass,
  input  logic i_bit,
  output logic o_bit
);

  logic [6:0] r_lfsr;
  logic       w_fb;

  assign w_fb  = lfsr_fb(r_lfsr);
  assign o_bit = i_bit ^ (w_fb & ~i_bypass);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lfsr <= SEED;
    end else if (i_load) begin
      r_lfsr <= SEED;
    end else if (i_adv) begin
      r_lfsr <= {r_lfsr[5:0], w_fb};
    end
  end

endmodule

// File: rtl/frame_sync_receiver.sv
// Serial frame receiver: preamble hunt, SFD alignment, length capture and
// descrambled payload streaming with one cycle of latency.
module frame_sync_receiver import rx_pkg::*; #(
  parameter int                PRE_MIN     = 32,
  parameter int                SFD_W       = 16,
  parameter logic [SFD_W-1:0]  SFD         = SFD_W'(DEF_SFD),
  parameter int                SFD_TIMEOUT = 64,
  parameter int                LEN_W       = 12,
  parameter int                MAX_LEN     = 4095,
  parameter bit                DESCRAMBLE  = 1'b1,
  parameter logic [6:0]        SEED        = DEF_SEED
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Input,
  output logic Output,
  output logic OutValid,
  output logic FrameStart,
  output logic FrameDone,
  output logic Error
);

  localparam int ALT_W  = $clog2(PRE_MIN + 1);
  localparam int TO_W   = $clog2(SFD_TIMEOUT + 1);
  localparam int LCNT_W = $clog2(LEN_W + 1);

  rx_state_t          r_state, w_next_state;
  logic               r_prev;
  logic [ALT_W-1:0]   r_alt, w_alt_nxt;
  logic [TO_W-1:0]    r_to, w_to_inc;
  logic [SFD_W-1:0]   r_sfd, w_sfd_nxt;
  logic [LEN_W-1:0]   r_len, w_len_nxt, r_pcnt;
  logic [LCNT_W-1:0]  r_lcnt;
  logic               w_len_bad;
  logic               w_fs, w_fd, w_err, w_ov, w_load, w_adv, w_dbit;
  logic               r_out, r_ov, r_fs, r_fd, r_err;

  always_comb begin
    w_sfd_nxt = {r_sfd[SFD_W-2:0], Input};
    w_len_nxt = {r_len[LEN_W-2:0], Input};
    if (Input != r_prev) begin
      w_alt_nxt = (r_alt == ALT_W'(PRE_MIN)) ? r_alt : r_alt + ALT_W'(1);
    end else begin
      w_alt_nxt = ALT_W'(1);
    end
    w_to_inc  = (r_to == TO_W'(SFD_TIMEOUT)) ? r_to : r_to + TO_W'(1);
    w_len_bad = (w_len_nxt == '0) ||
                ({{(32-LEN_W){1'b0}}, w_len_nxt} > 32'(MAX_LEN));
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= HUNT;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_fs   = 1'b0;
    w_fd   = 1'b0;
    w_err  = 1'b0;
    w_ov   = 1'b0;
    w_load = 1'b0;
    w_adv  = 1'b0;
    case (r_state)
      HUNT: begin
        if (w_alt_nxt == ALT_W'(PRE_MIN)) w_next_state = SYNC;
      end
      SYNC: begin
        if (w_sfd_nxt == SFD) begin
          w_fs         = 1'b1;
          w_next_state = LENGTH;
        end else if (w_to_inc == TO_W'(SFD_TIMEOUT)) begin
          w_err        = 1'b1;
          w_next_state = HUNT;
        end
      end
      LENGTH: begin
        if (r_lcnt == LCNT_W'(LEN_W - 1)) begin
          if (w_len_bad) begin
            w_err        = 1'b1;
            w_next_state = HUNT;
          end else begin
            w_load       = 1'b1;
            w_next_state = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        w_ov  = 1'b1;
        w_adv = 1'b1;
        if (r_pcnt <= LEN_W'(1)) begin
          w_fd         = 1'b1;
          w_next_state = HUNT;
        end
      end
      default: w_next_state = HUNT;
    endcase
  end

  descrambler_7 #(.SEED(SEED)) u_descr (
    .i_clk    (Clock),
    .i_rst    (Reset),
    .i_load   (w_load),
    .i_adv    (w_adv),
    .i_bypass (~DESCRAMBLE),
    .i_bit    (Input),
    .o_bit    (w_dbit)
  );

  // Counters are held at zero outside their own state so every frame starts clean.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_prev <= 1'b0;
      r_alt  <= '0;
      r_to   <= '0;
      r_sfd  <= '0;
      r_len  <= '0;
      r_lcnt <= '0;
      r_pcnt <= '0;
      r_out  <= 1'b0;
      r_ov   <= 1'b0;
      r_fs   <= 1'b0;
      r_fd   <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_prev <= Input;
      r_sfd  <= w_sfd_nxt;
      r_alt  <= (r_state == HUNT)   ? w_alt_nxt : '0;
      r_to   <= (r_state == SYNC)   ? w_to_inc  : '0;
      r_len  <= (r_state == LENGTH) ? w_len_nxt : '0;
      r_lcnt <= (r_state == LENGTH) ? r_lcnt + LCNT_W'(1) : '0;
      if (w_load) begin
        r_pcnt <= w_len_nxt;
      end else if (w_adv && (r_pcnt != '0)) begin
        r_pcnt <= r_pcnt - LEN_W'(1);
      end
      r_out <= w_ov ? w_dbit : 1'b0;
      r_ov  <= w_ov;
      r_fs  <= w_fs;
      r_fd  <= w_fd;
      r_err <= w_err;
    end
  end

  assign Output     = r_out;
  assign OutValid   = r_ov;
  assign FrameStart = r_fs;
  assign FrameDone  = r_fd;
  assign Error      = r_err;

endmodule

// File: tb/tb_frame_sync_receiver.sv
// Directed bench for frame_sync_receiver: a pass-through instance and a
// descrambling instance with a reduced MAX_LEN share one serial stream.
module tb_frame_sync_receiver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic out0, ov0, fs0, fd0, err0;
  logic out1, ov1, fs1, fd1, err1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  frame_sync_receiver #(.DESCRAMBLE(1'b0)) u_dut0 (
    .Clock(clk), .Reset(rst), .Input(din),
    .Output(out0), .OutValid(ov0), .FrameStart(fs0), .FrameDone(fd0), .Error(err0)
  );

  frame_sync_receiver #(.DESCRAMBLE(1'b1), .MAX_LEN(100)) u_dut1 (
    .Clock(clk), .Reset(rst), .Input(din),
    .Output(out1), .OutValid(ov1), .FrameStart(fs1), .FrameDone(fd1), .Error(err1)
  );

  task automatic tick(input logic b);
    din = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    din = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_preamble(input int n);
    for (int i = 0; i < n; i++) tick(~i[0]);
  endtask

  task automatic send_word(input logic [15:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) tick(w[i]);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = i[0];
      @(posedge clk);
      #1;
    end
    checks++;
    if ({out0, ov0, fs0, fd0, err0, out1, ov1, fs1, fd1, err1} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0000000000",
               {out0, ov0, fs0, fd0, err0, out1, ov1, fs1, fd1, err1});
    end
    checks++;
    if (u_dut0.r_state !== rx_pkg::HUNT) begin
      errors++;
      $display("FAIL reset_state got %0d exp %0d", u_dut0.r_state, rx_pkg::HUNT);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [3:0] pl;
    pl = 4'b1001;
    do_reset();
    send_preamble(40);
    send_word(16'hF3A0, 16);
    checks++;
    if (fs0 !== 1'b1) begin
      errors++; $display("FAIL basic_framestart got %b exp 1", fs0);
    end
    tick(1'b0);
    checks++;
    if (fs0 !== 1'b0) begin
      errors++; $display("FAIL basic_framestart_pulse got %b exp 0", fs0);
    end
    send_word(16'd4, 11);
    checks++;
    if ({ov0, err0} !== 2'b00) begin
      errors++; $display("FAIL basic_after_len got %b exp 00", {ov0, err0});
    end
    for (int i = 0; i < 4; i++) begin
      tick(pl[3-i]);
      checks++;
      if ({out0, ov0, fd0, err0} !== {pl[3-i], 1'b1, (i == 3), 1'b0}) begin
        errors++;
        $display("FAIL basic_payload_%0d got %b exp %b", i, {out0, ov0, fd0, err0},
                 {pl[3-i], 1'b1, (i == 3), 1'b0});
      end
    end
    tick(1'b0);
    checks++;
    if ({ov0, fd0} !== 2'b00) begin
      errors++; $display("FAIL basic_end got %b exp 00", {ov0, fd0});
    end
  endtask

  task automatic test_descramble();
    logic [7:0] exp;
    exp = 8'b0000_1110;
    do_reset();
    send_preamble(40);
    send_word(16'hF3A0, 16);
    send_word(16'd8, 12);
    for (int i = 0; i < 8; i++) begin
      tick(1'b0);
      checks++;
      if ({out1, ov1, fd1, out0} !== {exp[7-i], 1'b1, (i == 7), 1'b0}) begin
        errors++;
        $display("FAIL descr_bit_%0d got %b exp %b", i, {out1, ov1, fd1, out0},
                 {exp[7-i], 1'b1, (i == 7), 1'b0});
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send_preamble(40);
    for (int k = 0; k < 64; k++) begin
      tick(1'b0);
      checks++;
      if ({err0, err1, ov0, fs0} !== {(k == 55), (k == 55), 2'b00}) begin
        errors++;
        $display("FAIL timeout_cycle_%0d got %b exp %b", k, {err0, err1, ov0, fs0},
                 {(k == 55), (k == 55), 2'b00});
      end
    end
  endtask

  task automatic test_illegal_len();
    logic [2:0] pl;
    pl = 3'b110;
    do_reset();
    send_preamble(40);
    send_word(16'hF3A0, 16);
    send_word(16'd0, 12);
    checks++;
    if ({err0, err1, ov0} !== 3'b110) begin
      errors++; $display("FAIL len0_error got %b exp 110", {err0, err1, ov0});
    end
    tick(1'b0);
    checks++;
    if (err0 !== 1'b0 || u_dut0.r_state !== rx_pkg::HUNT) begin
      errors++; $display("FAIL len0_recover got err=%b state=%0d exp err=0 state=0",
                         err0, u_dut0.r_state);
    end
    send_preamble(40);
    send_word(16'hF3A0, 16);
    checks++;
    if (fs0 !== 1'b1) begin
      errors++; $display("FAIL len0_next_fs got %b exp 1", fs0);
    end
    send_word(16'd3, 12);
    for (int i = 0; i < 3; i++) begin
      tick(pl[2-i]);
      checks++;
      if ({out0, ov0, fd0} !== {pl[2-i], 1'b1, (i == 2)}) begin
        errors++;
        $display("FAIL len0_next_bit_%0d got %b exp %b", i, {out0, ov0, fd0},
                 {pl[2-i], 1'b1, (i == 2)});
      end
    end
    // dut1 caps the length at 100: 101 is illegal there, 100 is legal.
    do_reset();
    send_preamble(40);
    send_word(16'hF3A0, 16);
    send_word(16'd101, 12);
    checks++;
    if ({err1, err0} !== 2'b10) begin
      errors++; $display("FAIL maxlen_over got %b exp 10", {err1, err0});
    end
    tick(1'b0);
    checks++;
    if ({ov1, ov0} !== 2'b01) begin
      errors++; $display("FAIL maxlen_over_valid got %b exp 01", {ov1, ov0});
    end
    do_reset();
    send_preamble(40);
    send_word(16'hF3A0, 16);
    send_word(16'd100, 12);
    checks++;
    if ({err1, err0} !== 2'b00) begin
      errors++; $display("FAIL maxlen_edge got %b exp 00", {err1, err0});
    end
    tick(1'b0);
    checks++;
    if ({ov1, ov0} !== 2'b11) begin
      errors++; $display("FAIL maxlen_edge_valid got %b exp 11", {ov1, ov0});
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] pl;
    pl = 4'b0110;
    do_reset();
    send_preamble(40);
    send_word(16'hF3A0, 16);
    send_word(16'd8, 12);
    tick(1'b1);
    tick(1'b0);
    checks++;
    if ({ov0, out0} !== 2'b10) begin
      errors++; $display("FAIL midrst_pre got %b exp 10", {ov0, out0});
    end
    din = 1'b1;
    rst = 1'b1;
    #1;
    checks++;
    if ({ov0, fd0, err0, out0, ov1} !== 5'b0) begin
      errors++; $display("FAIL midrst_drop got %b exp 00000", {ov0, fd0, err0, out0, ov1});
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0);
      checks++;
      if ({ov0, fd0, err0} !== 3'b000) begin
        errors++; $display("FAIL midrst_quiet_%0d got %b exp 000", i, {ov0, fd0, err0});
      end
    end
    send_preamble(40);
    send_word(16'hF3A0, 16);
    send_word(16'd4, 12);
    for (int i = 0; i < 4; i++) begin
      tick(pl[3-i]);
      checks++;
      if ({out0, ov0, fd0} !== {pl[3-i], 1'b1, (i == 3)}) begin
        errors++;
        $display("FAIL midrst_next_bit_%0d got %b exp %b", i, {out0, ov0, fd0},
                 {pl[3-i], 1'b1, (i == 3)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_descramble();
    test_timeout();
    test_illegal_len();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
